ps2_keyboard_rx: RTL

- Receives PS/2 keyboard frames on ps2_clk/ps2_data and produces the kb_up/kb_data key-event interface used by the image-processor mode controller.
- Synchronises and filters the line, deserialises 11-bit frames, and checks parity and stop bits.
- Tracks the F0 (break) and E0 (extended) prefixes and emits a one-cycle kb_up pulse with the released key's scan code.
- Sits between the board PS/2 pins and the mode controller.

---
 rtl/ps2_keyboard_rx_pkg.sv | 36 +++
 rtl/ps2_line_filter.sv | 56 +++++
 rtl/ps2_keyboard_rx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_rx_pkg.sv
// rtl/ps2_keyboard_rx_pkg.sv - shared constants, FSM encoding and scan codes for the PS/2 receiver
package ps2_keyboard_rx_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Scan codes the mode controller reacts to
    localparam logic [7:0] SC_KEY_1 = 8'h16;
    localparam logic [7:0] SC_KEY_2 = 8'h1E;
    localparam logic [7:0] SC_KEY_3 = 8'h26;
    localparam logic [7:0] SC_KEY_4 = 8'h25;
    localparam logic [7:0] SC_KEY_5 = 8'h2E;
    localparam logic [7:0] SC_KEY_6 = 8'h36;
    localparam logic [7:0] SC_KEY_P = 8'h4D;
    localparam logic [7:0] SC_KEY_A = 8'h1C;
    localparam logic [7:0] SC_KEY_S = 8'h1B;
    localparam logic [7:0] SC_KEY_D = 8'h23;
    localparam logic [7:0] SC_KEY_F = 8'h2B;
    localparam logic [7:0] SC_KEY_G = 8'h34;
    localparam logic [7:0] SC_KEY_Q = 8'h15;

    // Frame trailer is good when the stop bit is high and data+parity has odd weight
    function automatic logic frame_ok(input logic [7:0] data_byte,
                                      input logic       parity_bit,
                                      input logic       stop_bit);
        return stop_bit && ((^data_byte ^ parity_bit) == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchronisers, clock glitch filter and falling-edge strobe
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic fe
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          clk_meta;
    logic          clk_sync;
    logic          data_meta;
    logic          clk_filt;
    logic [CW-1:0] filt_cnt;

    // Two-flop synchronisers; both lines idle high
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // Filtered clock follows only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fe       <= 1'b0;
        end else begin
            fe <= 1'b0;
            if (clk_sync == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync;
                filt_cnt <= '0;
                fe       <= ~clk_sync;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver with break/extended key-release decoder
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       kb_up,
    output logic [7:0] kb_data,
    output logic       kb_ext,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic          fe;
    logic          ps2_bit;
    ps2_state_e    state;
    ps2_state_e    state_n;
    logic [7:0]    shift_q;
    logic [7:0]    shift_n;
    logic [2:0]    bitcnt_q;
    logic [2:0]    bitcnt_n;
    logic          parity_q;
    logic          parity_n;
    logic [TW-1:0] tcnt;
    logic          timeout_hit;
    logic          byte_valid;
    logic          byte_valid_n;
    logic          frame_err_n;
    logic          brk;
    logic          ext;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_line_filter (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_sync(ps2_bit),
        .fe       (fe)
    );

    // Timeout fires on the edge where the counter becomes TIMEOUT_CYCLES-1; an fe wins
    assign timeout_hit = (state != IDLE) && !fe && (tcnt == TW'(TIMEOUT_CYCLES - 2));

    // Frame FSM next-state: one bit consumed per filtered falling edge
    always_comb begin
        state_n      = state;
        shift_n      = shift_q;
        bitcnt_n     = bitcnt_q;
        parity_n     = parity_q;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        if (timeout_hit) begin
            state_n     = IDLE;
            frame_err_n = 1'b1;
        end else if (fe) begin
            case (state)
                IDLE: begin
                    if (!ps2_bit) begin
                        state_n  = DATA;
                        bitcnt_n = 3'd0;
                        shift_n  = 8'h00;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
                DATA: begin
                    shift_n[bitcnt_q] = ps2_bit;
                    bitcnt_n          = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    parity_n = ps2_bit;
                    state_n  = STOP;
                end
                STOP: begin
                    if (frame_ok(shift_q, parity_q, ps2_bit)) begin
                        byte_valid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Frame FSM registers and the one-cycle byte_valid / frame_err strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            shift_q    <= 8'h00;
            bitcnt_q   <= 3'd0;
            parity_q   <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            shift_q    <= shift_n;
            bitcnt_q   <= bitcnt_n;
            parity_q   <= parity_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    // Inter-edge watchdog: idle and every falling edge restart it
    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (fe || state == IDLE) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Break/extended prefix tracking and key-release output
    always_ff @(posedge clk) begin
        if (!rst) begin
            kb_up   <= 1'b0;
            kb_data <= 8'h00;
            kb_ext  <= 1'b0;
            brk     <= 1'b0;
            ext     <= 1'b0;
        end else begin
            kb_up <= 1'b0;
            if (byte_valid) begin
                if (shift_q == PS2_BREAK) begin
                    brk <= 1'b1;
                end else if (shift_q == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (brk) begin
                    kb_data <= shift_q;
                    kb_ext  <= ext;
                    kb_up   <= 1'b1;
                    brk     <= 1'b0;
                    ext     <= 1'b0;
                end else begin
                    ext <= 1'b0;
                end
            end
        end
    end

endmodule
